// File: rtl/sd_spi_host.sv
// SD card SPI host: byte-wide mode-0 shifter with a two-register host port.
// The SCK timebase advances on ce strobes only. Slow mode stretches each
// half-period to SLOW_DIV strobes for card initialisation.
module sd_spi_host #(
  parameter int SLOW_DIV = 70
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       sd_cs_n
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_reg_q, rx_reg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  hp_cnt_q, hp_cnt_d;
  logic        cs_n_q, cs_n_d;
  logic        slow_q, slow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  logic        wr_ok;
  logic        hp_last;

  // Writes are only honoured while no byte is in flight.
  assign wr_ok   = wr && !busy_q;
  // Current ce strobe closes the half-period.
  assign hp_last = slow_q ? (hp_cnt_q == 7'(SLOW_DIV - 1)) : 1'b1;

  // Next-state logic: register port plus the SCK half-period sequencer.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_reg_d  = rx_reg_q;
    bit_cnt_d = bit_cnt_q;
    hp_cnt_d  = hp_cnt_q;
    cs_n_d    = cs_n_q;
    slow_d    = slow_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sck_d     = sck_q;
    mosi_d    = mosi_q;

    if (wr_ok && addr) begin
      cs_n_d = din[0];
      slow_d = din[1];
    end

    case (state_q)
      S_IDLE: begin
        if (wr_ok && !addr) begin
          tx_d      = din;
          bit_cnt_d = 3'd0;
          hp_cnt_d  = 7'd0;
          mosi_d    = din[7];
          busy_d    = 1'b1;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (ce) begin
          if (hp_last) begin
            // Rising SCK: capture the card's bit on this same edge.
            hp_cnt_d = 7'd0;
            sck_d    = 1'b1;
            rx_sh_d  = {rx_sh_q[6:0], sd_miso};
            state_d  = S_HIGH;
          end else begin
            hp_cnt_d = hp_cnt_q + 7'd1;
          end
        end
      end
      S_HIGH: begin
        if (ce) begin
          if (hp_last) begin
            // Falling SCK: either present the next bit or finish the byte.
            hp_cnt_d = 7'd0;
            sck_d    = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              mosi_d   = 1'b1;
              rx_reg_d = rx_sh_q;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_d      = {tx_q[6:0], 1'b0};
              mosi_d    = tx_q[6];
              state_d   = S_LOW;
            end
          end else begin
            hp_cnt_d = hp_cnt_q + 7'd1;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and pin registers, cleared asynchronously.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rx_reg_q  <= 8'hFF;
      bit_cnt_q <= 3'd0;
      hp_cnt_q  <= 7'd0;
      cs_n_q    <= 1'b1;
      slow_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      rx_reg_q  <= rx_reg_d;
      bit_cnt_q <= bit_cnt_d;
      hp_cnt_q  <= hp_cnt_d;
      cs_n_q    <= cs_n_d;
      slow_q    <= slow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

  // Shift registers carry pure data and need no reset.
  always_ff @(posedge clk_sys) begin
    tx_q    <= tx_d;
    rx_sh_q <= rx_sh_d;
  end

  assign dout    = addr ? {5'b0, busy_q, slow_q, cs_n_q} : rx_reg_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sd_clk  = sck_q;
  assign sd_mosi = mosi_q;
  assign sd_cs_n = cs_n_q;

endmodule

// File: tb/tb_sd_spi_host.sv
// Bench for sd_spi_host: directed scenarios plus randomized byte transfers
// against a byte-level card/host model.
module tb_sd_spi_host;

  localparam int SLOW_DIV = 70;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       wr;
  logic       addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic       sd_clk;
  logic       sd_mosi;
  logic       sd_miso;
  logic       sd_cs_n;

  sd_spi_host #(.SLOW_DIV(SLOW_DIV)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .wr      (wr),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .busy    (busy),
    .done    (done),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso),
    .sd_cs_n (sd_cs_n)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // ce generator settings
  int ce_period = 4;
  bit ce_en     = 1'b1;
  bit ce_rand   = 1'b0;
  int ce_phase  = 0;
  bit ce_prev   = 1'b0;

  // monitor state
  int ce_cnt = 0, rises = 0, falls = 0, dones = 0, hp_err = 0, mosi_viol = 0;
  int last_edge_ce = 0, exp_hp = 1;
  logic [7:0] cap = 8'h00;
  logic [7:0] resp = 8'h00;
  logic [7:0] model_rx = 8'hFF;
  bit loop_mode = 1'b0;
  logic prev_sck = 1'b0, prev_mosi = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Card model: loopback, or shift out resp MSB first, advancing on falling SCK.
  task automatic drive_miso();
    if (loop_mode) sd_miso = sd_mosi;
    else sd_miso = (falls < 8) ? resp[7 - falls] : 1'b1;
  endtask

  // One clk_sys cycle: drive ce, advance, then observe the pins.
  task automatic step();
    if (!ce_en) ce = 1'b0;
    else if (ce_rand) ce = !ce_prev && ($urandom_range(0, 2) == 0);
    else ce = (ce_phase == ce_period - 1);
    @(posedge clk_sys);
    #1;
    ce_prev  = ce;
    ce_phase = (ce_phase + 1) % ce_period;
    if (ce) ce_cnt++;
    if (sd_clk !== prev_sck) begin
      if (ce_cnt - last_edge_ce != exp_hp) hp_err++;
      last_edge_ce = ce_cnt;
      if (sd_clk) begin
        rises++;
        cap = {cap[6:0], sd_mosi};
      end else begin
        falls++;
      end
    end else if (sd_clk && (sd_mosi !== prev_mosi)) begin
      mosi_viol++;
    end
    if (done) dones++;
    prev_sck  = sd_clk;
    prev_mosi = sd_mosi;
    drive_miso();
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic a, output logic [7:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  // mode 0: plain, 1: writes while busy, 2: ce held low mid-transfer
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rsp, input bit lp,
                      input bit slw, input int mode);
    int div, budget, n, start_ce, frz;
    bit gated;
    logic [7:0] exp_rx, r, ctrl_before;
    logic f_sck, f_mosi, f_busy;
    div = slw ? SLOW_DIV : 1;
    exp_hp = div; resp = rsp; loop_mode = lp;
    rises = 0; falls = 0; dones = 0; hp_err = 0; mosi_viol = 0; cap = 8'h00;
    exp_rx = lp ? tx : rsp;
    gated = 1'b0; frz = 0;
    rd_reg(1'b1, ctrl_before);
    drive_miso();
    wr_reg(1'b0, tx);
    last_edge_ce = ce_cnt;
    start_ce = ce_cnt;
    chk("busy_after_wr", busy, 1'b1);
    budget = 16 * div * 8 + 300;
    n = 0;
    while (dones == 0 && n < budget) begin
      wr = 1'b0;
      if (mode == 1 && n == 3) begin
        wr = 1'b1; addr = 1'b0; din = 8'h00;
      end else if (mode == 1 && n == 4) begin
        wr = 1'b1; addr = 1'b1; din = {6'b0, ctrl_before[1], ~ctrl_before[0]};
      end
      if (n == 5) begin
        rd_reg(1'b0, r);
        chk("rx_during_xfer", r, model_rx);
      end
      if (mode == 2 && rises == 3 && !gated) begin
        gated = 1'b1;
        ce_en = 1'b0;
        f_sck = sd_clk; f_mosi = sd_mosi; f_busy = busy;
        for (int i = 0; i < 100; i++) begin
          step();
          if (sd_clk !== f_sck || sd_mosi !== f_mosi || busy !== f_busy) frz++;
        end
        ce_en = 1'b1;
        chk("ce_freeze", frz, 0);
      end
      step();
      n++;
    end
    wr = 1'b0;
    chk("done_seen", dones, 1);
    chk("ce_to_done", ce_cnt - start_ce, 16 * div);
    if (mode == 1) begin
      // write in the cycle done is high must be dropped
      wr_reg(1'b0, 8'hC3);
    end else begin
      step();
    end
    repeat (3) step();
    chk("busy_idle", busy, 1'b0);
    chk("one_done", dones, 1);
    chk("sck_pulses", rises, 8);
    chk("mosi_bits", cap, tx);
    chk("half_period_len", hp_err, 0);
    chk("mosi_stable_high", mosi_viol, 0);
    chk("mosi_idle", sd_mosi, 1'b1);
    chk("sck_idle", sd_clk, 1'b0);
    rd_reg(1'b0, r);
    chk("rx_data", r, exp_rx);
    rd_reg(1'b1, r);
    chk("ctrl_after", r, {6'b0, ctrl_before[1:0]});
    chk("cs_pin", sd_cs_n, ctrl_before[0]);
    model_rx = exp_rx;
  endtask

  task automatic reset_mid_xfer(input logic [7:0] tx);
    int n;
    logic [7:0] r;
    wr_reg(1'b1, 8'h00);
    exp_hp = 1; loop_mode = 1'b1;
    rises = 0; falls = 0; dones = 0;
    drive_miso();
    wr_reg(1'b0, tx);
    last_edge_ce = ce_cnt;
    n = 0;
    while (rises < 5 && n < 400) begin
      step();
      n++;
    end
    chk("reset_reach_5", rises, 5);
    reset_n = 1'b0;
    #1;
    chk("rst_sck", sd_clk, 1'b0);
    chk("rst_mosi", sd_mosi, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cs", sd_cs_n, 1'b1);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();
    chk("rst_no_done", dones, 0);
    model_rx = 8'hFF;
    rd_reg(1'b0, r);
    chk("rst_rx", r, 8'hFF);
    rd_reg(1'b1, r);
    chk("rst_ctrl", r, 8'h03);
    wr_reg(1'b1, 8'h00);
    rd_reg(1'b1, r);
    chk("first_wr_after_rst", r, 8'h00);
  endtask

  initial begin
    logic [7:0] r;
    reset_n = 1'b0; ce = 1'b0; wr = 1'b0; addr = 1'b0; din = 8'h00; sd_miso = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    // post-reset state
    rd_reg(1'b1, r);
    chk("reset_ctrl", r, 8'h03);
    rd_reg(1'b0, r);
    chk("reset_data", r, 8'hFF);
    chk("reset_cs", sd_cs_n, 1'b1);
    chk("reset_mosi", sd_mosi, 1'b1);
    chk("reset_sck", sd_clk, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // fast loopback
    ce_period = 4;
    wr_reg(1'b1, 8'h00);
    xfer(8'hA5, 8'h00, 1'b1, 1'b0, 0);

    // slow mode with card response
    wr_reg(1'b1, 8'h02);
    xfer(8'hFF, 8'h3C, 1'b0, 1'b1, 0);

    // writes while busy
    wr_reg(1'b1, 8'h00);
    xfer(8'h55, 8'($urandom), 1'b0, 1'b0, 1);

    // ce gating
    xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0, 2);

    // reset mid-transfer, then a normal transfer
    reset_mid_xfer(8'h5A);
    xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0, 0);

    // randomized fast transfers
    for (int k = 0; k < 12; k++) begin
      ce_rand   = ($urandom_range(0, 1) == 1);
      ce_period = $urandom_range(1, 5);
      ce_phase  = 0;
      wr_reg(1'b1, {7'b0, 1'($urandom_range(0, 1))});
      xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0,
           $urandom_range(0, 2));
    end

    // one randomized slow transfer with dense ce
    ce_rand = 1'b0; ce_period = 1; ce_phase = 0;
    wr_reg(1'b1, {6'b0, 1'b1, 1'($urandom_range(0, 1))});
    xfer(8'($urandom), 8'($urandom), 1'b0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_host.md
SD_SPI_HOST -- requirements
Module: sd_spi_host

Interface
REQ-001 Parameter SLOW_DIV, default 70: number of ce pulses per SCK half-period in slow (card-init) mode; legal range 1..127.
REQ-002 clk_sys  input  1  single system clock; all logic is clocked on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ce  input  1  clock-enable strobe, one clk_sys cycle wide; the SPI timebase advances only when ce=1.
REQ-005 wr  input  1  register write strobe, one clk_sys cycle wide.
REQ-006 addr  input  1  register select: 0 = data, 1 = control.
REQ-007 din  input  8  write data.
REQ-008 dout  output  8  read data for the selected register; combinational from addr.
REQ-009 busy  output  1  high while a byte transfer is in progress.
REQ-010 done  output  1  one-clk_sys pulse when a transfer completes.
REQ-011 sd_clk  output  1  SPI SCK, mode 0.
REQ-012 sd_mosi  output  1  SPI data to card.
REQ-013 sd_miso  input  1  SPI data from card.
REQ-014 sd_cs_n  output  1  card select, active-low.

Function
REQ-015 Control write (addr=1, wr=1, busy=0) SHALL latch cs_n_reg=din[0] and slow_reg=din[1]; other bits are ignored.
REQ-016 Control read SHALL return {5'b0, busy, slow_reg, cs_n_reg}.
REQ-017 Data write (addr=0, wr=1, busy=0) SHALL load the transmit shift register with din, clear the bit and half-period counters, and assert busy on the next clk_sys edge.
REQ-018 Any write while busy=1 SHALL be ignored, including a write in the same cycle done pulses.
REQ-019 State machine: IDLE -> (data write) -> LOW -> (half-period elapsed) -> HIGH -> (half-period elapsed) -> LOW, or -> DONE after the 8th HIGH -> IDLE.
REQ-020 A half-period SHALL elapse after 1 ce pulse when slow_reg=0 and after SLOW_DIV ce pulses when slow_reg=1; the count restarts at each SCK edge.
REQ-021 sd_clk SHALL be 0 in IDLE, LOW and DONE, and 1 in HIGH.
REQ-022 sd_mosi SHALL present the transmit MSB first, be stable for the whole LOW half-period before each rising edge, and change only on a falling SCK edge.
REQ-023 sd_miso SHALL be sampled on the clk_sys edge that enters HIGH (rising SCK) and shifted into the receive register LSB-first-in, so the first sampled bit ends as bit 7.
REQ-024 A byte SHALL take exactly 16 half-periods: 16 ce pulses in fast mode, 16*SLOW_DIV in slow mode.
REQ-025 DONE SHALL last one clk_sys cycle: the received byte is copied to rx_reg, done=1, busy is deasserted entering IDLE; data read returns rx_reg.
REQ-026 A data read during a transfer SHALL return the previous rx_reg value.
REQ-027 In IDLE sd_mosi SHALL be 1.
REQ-028 sd_cs_n SHALL equal cs_n_reg; the block never toggles CS on its own.
REQ-029 When ce=0 the state machine and counters SHALL hold; register writes and reads still operate.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE, busy=0, done=0, sd_clk=0, sd_mosi=1, cs_n_reg=1 (sd_cs_n=1), slow_reg=1, rx_reg=8'hFF, counters=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; after release the block accepts a new write on the first cycle.

Verification
REQ-032 Post-reset: release reset_n, read control -> 8'h03, read data -> 8'hFF, sd_cs_n=1, sd_mosi=1, sd_clk=0.
REQ-033 Fast loopback: ce every 4 clk, ctrl write 8'h00, miso tied to mosi, data write 8'hA5 -> exactly 8 sd_clk pulses, mosi pattern 1,0,1,0,0,1,0,1, done after 16 ce pulses, data read 8'hA5.
REQ-034 Slow mode: ctrl write 8'h02 (SLOW_DIV=70), card model returns 8'h3C, data write 8'hFF -> sd_clk high and low each 70 ce pulses, done after 1120 ce pulses, data read 8'h3C.
REQ-035 Write while busy: during a transfer of 8'h55, data write 8'h00 and ctrl write 8'h01 -> transmitted bits remain 8'h55, sd_cs_n unchanged, exactly one done pulse.
REQ-036 Reset mid-transfer: assert reset_n=0 after 5 sd_clk pulses -> sd_clk=0, sd_mosi=1, busy=0 within the same cycle, no done, data read 8'hFF.
REQ-037 ce gating: hold ce=0 for 100 clk mid-transfer -> sd_clk, sd_mosi and busy are frozen; the transfer then completes with the correct byte.
